digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

Parametrised, multi-cycle add/subtract unit that processes WIDTH-bit operands DIGIT bits per clock, with a carry flip-flop between digits. It trades latency for area against the single-cycle half and full adders. Its start/done handshake lets a controller launch one operation at a time and collect S, C and V when done pulses.

## Interface
- WIDTH, default 8: operand/result width; must be an integer multiple of DIGIT, ≥ 2.
- DIGIT, default 1: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  launch request; sampled only while the block is ready.
- SUB  in  1  mode, captured with start: 0 = A+B, 1 = A−B.
- A  in  WIDTH  operand A, unsigned or two's complement, captured with start.
- B  in  WIDTH  operand B, captured with start.
- busy  out  1  high while an operation is in progress (state RUN).
- done  out  1  one-cycle pulse: S, C and V are valid.
- S  out  WIDTH  sum/difference, modulo 2^WIDTH.
- C  out  1  carry-out; for SUB, 1 = no borrow (A ≥ B unsigned).
- V  out  1  signed overflow.

## Operation
- The FSM has three states: IDLE, RUN and DONE. K = WIDTH/DIGIT.
- IDLE: busy=0, done=0. If start=1, the block does the following:
  - Latch A, and B (or ~B when SUB=1), into shift registers.
  - Load the carry FF with SUB.
  - Clear the digit counter.
  - Go to RUN.
- RUN: busy=1. Each cycle, the block does the following:
  - Add the low DIGIT bits of both registers plus the carry FF.
  - Shift the DIGIT-bit result into the top of the S register, LSB digit first.
  - Store the digit carry-out in the carry FF.
  - Shift the operands right by DIGIT bits.
- On the K-th RUN cycle, the block goes to DONE.
- DONE: done=1 and busy=0 for exactly one cycle.
  - C = final carry FF.
  - V = carry into MSB XOR carry out of MSB. V is computed from the top digit's internal carry.
  - The state returns to IDLE.
- A start seen in DONE is accepted: the block loads and goes straight to RUN for back-to-back operations.
- A start seen in RUN is ignored. It is not queued.
- S, C and V hold their last values until the next DONE. They change only on entering DONE.
- A, B and SUB are don't-care except in the accepting cycle.
- With DIGIT = WIDTH (K=1), the block still takes one RUN cycle and one DONE cycle.

## Timing
- Reset (rst_n=0 at a rising edge) forces the following values:
  - State = IDLE.
  - busy=0, done=0, S=0, C=0, V=0.
  - Counter, operand registers and carry FF cleared.
- Reset overrides start and abandons any operation in flight; no done pulse is produced for it.
- If start is accepted at edge t, then:
  - busy=1 in cycles t+1 … t+K.
  - done=1 in cycle t+K+1.
  - Latency is K+1 edges.
- Throughput is one operation per K+1 cycles, with start held or re-asserted during DONE.
- The first start accepted after reset release must be sampled at an edge where rst_n=1.
- All outputs are registered, with no combinational path from inputs to outputs.
- The digit counter is ceil(log2(K+1)) bits wide and saturates at K.

## Structure
- Package digit_serial_adder_pkg holds the following:
  - Typedef state_t {IDLE, RUN, DONE}.
  - Localparams MODE_ADD=1'b0 and MODE_SUB=1'b1.
- One sub-module, digit_adder, is natural. It is a combinational DIGIT-bit ripple adder with the following ports:
  - Inputs a, b, cin.
  - Outputs s, cout, and c_msb_in (carry into the top bit, used for V).
- The top level holds the FSM, counter, shift registers and carry FF.

## Test plan
- Reset: drive rst_n=0 mid-RUN (WIDTH=8, DIGIT=1, A=8'hFF, B=8'h01) → next cycle busy=0, S=0, C=0, V=0; no done pulse follows.
- Add, DIGIT=1:
  - Stimulus: A=8'h7F, B=8'h01, SUB=0.
  - Required response: done exactly 9 cycles after start, S=8'h80, C=0, V=1.
  - Check that busy is high for 8 cycles.
- Carry-out, DIGIT=4:
  - Stimulus: A=8'hFF, B=8'h01, SUB=0.
  - Required response: done 3 cycles after start, S=8'h00, C=1, V=0.
- Subtract with borrow, DIGIT=2:
  - Stimulus: A=8'h03, B=8'h05, SUB=1.
  - Required response: done after 5 cycles, S=8'hFE, C=0, V=0.
  - Next operation: A=8'h80, B=8'h01, SUB=1 → S=8'h7F, C=1, V=1.
- Handshake:
  - Pulse start again during RUN with different operands → ignored; the result matches the first operands.
  - Start held high through DONE → the second operation begins with no IDLE gap.
  - Check that done is one cycle wide.
- Sweep: WIDTH=8, DIGIT ∈ {1,2,4,8}, all 2^16 A/B pairs for both SUB values, checked against A+B and A−B.
  - S, C and V match the reference arithmetic.
  - Latency is K+1 in every case.

Source files
------------

// File: rtl/digit_serial_adder_pkg.sv
// Shared types and constants for the digit-serial add/subtract unit.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder. Also exposes the carry into the top
// bit so the caller can form signed overflow from the most significant digit.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  // Ripple the carry bit by bit; a block-local carry keeps the chain acyclic.
  always_comb begin : ripple
    logic cy;
    cy       = cin;
    s        = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = cy;
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    cout = cy;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/subtract: consumes DIGIT bits of each operand per clock,
// carrying between digits through a flip-flop. Subtraction is A + ~B + 1,
// with the +1 supplied by preloading the carry FF with the mode bit.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one digit per cycle, K cycles
//   DONE  | one-cycle done pulse; a new start is accepted here
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(K);

  state_t state, state_nxt;

  logic [WIDTH-1:0]       a_reg, b_reg, s_reg;
  logic                   carry_ff;
  logic [CW-1:0]          cnt;
  logic [DIGIT-1:0]       dig_s;
  logic                   dig_cout, dig_cmsb;
  logic [WIDTH+DIGIT-1:0] s_cat;
  logic [WIDTH-1:0]       s_next;
  logic                   load, last;

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a        (a_reg[DIGIT-1:0]),
    .b        (b_reg[DIGIT-1:0]),
    .cin      (carry_ff),
    .s        (dig_s),
    .cout     (dig_cout),
    .c_msb_in (dig_cmsb)
  );

  // New digit enters at the top; concatenation keeps this valid for K=1.
  assign s_cat  = {dig_s, s_reg};
  assign s_next = s_cat[WIDTH+DIGIT-1:DIGIT];

  // Starts are honoured only outside RUN; DONE accepts for back-to-back ops.
  assign load = start && (state != RUN);
  assign last = (state == RUN) && (cnt == CNT_LAST);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, digit shifting, carry chain and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      s_reg    <= '0;
      carry_ff <= 1'b0;
      cnt      <= '0;
      S        <= '0;
      C        <= 1'b0;
      V        <= 1'b0;
    end else if (load) begin
      a_reg    <= A;
      b_reg    <= (SUB == MODE_SUB) ? ~B : B;
      carry_ff <= SUB;
      cnt      <= '0;
    end else if (state == RUN) begin
      a_reg    <= a_reg >> DIGIT;
      b_reg    <= b_reg >> DIGIT;
      s_reg    <= s_next;
      carry_ff <= dig_cout;
      if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
      if (last) begin
        S <= s_next;
        C <= dig_cout;
        V <= dig_cout ^ dig_cmsb;
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench: four instances (DIGIT = 1, 2, 4, 8 at WIDTH = 8) sharing
// operands and reset, each with its own start.
module tb_digit_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start;
  logic       SUB;
  logic [7:0] A, B;
  logic [3:0] busy, done, c_o, v_o;
  logic [7:0] s_o [4];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    digit_serial_adder #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start[g]),
      .SUB   (SUB),
      .A     (A),
      .B     (B),
      .busy  (busy[g]),
      .done  (done[g]),
      .S     (s_o[g]),
      .C     (c_o[g]),
      .V     (v_o[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {V, C, S} from whole-word arithmetic and the sign rule.
  function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic sub);
    logic [7:0] bb;
    logic [8:0] sum;
    logic       v;
    bb  = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
    v   = (a[7] == bb[7]) && (sum[7] != a[7]);
    return {v, sum[8], sum[7:0]};
  endfunction

  // Caller sits #1 after the accepting edge (cycle t+1). Returns the edge
  // count from acceptance to the done cycle and the busy cycles seen.
  task automatic wait_done(input int idx, output int lat, output int nbusy);
    bit got;
    got   = 0;
    lat   = 1;
    nbusy = busy[idx] ? 1 : 0;
    if (done[idx]) got = 1;
    while (!got && lat < 24) begin
      @(posedge clk);
      lat++;
      #1;
      if (done[idx]) got = 1;
      else if (busy[idx]) nbusy++;
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic sub, output int lat, output int nbusy);
    @(negedge clk);
    A = a; B = b; SUB = sub; start[idx] = 1'b1;
    @(posedge clk);
    #1;
    start[idx] = 1'b0;
    wait_done(idx, lat, nbusy);
  endtask

  // Runs one op, checks result and latency, and that done lasts one cycle.
  task automatic op_check(input string tag, input int idx, input logic [7:0] a,
                          input logic [7:0] b, input logic sub);
    int lat, nb, k;
    logic [9:0] r;
    k = 8 >> idx;
    r = ref_op(a, b, sub);
    run_op(idx, a, b, sub, lat, nb);
    chk({tag, "_S"},   32'(s_o[idx]), 32'(r[7:0]));
    chk({tag, "_C"},   32'(c_o[idx]), 32'(r[8]));
    chk({tag, "_V"},   32'(v_o[idx]), 32'(r[9]));
    chk({tag, "_lat"}, 32'(lat),      32'(k + 1));
    chk({tag, "_bsy"}, 32'(nb),       32'(k));
    @(posedge clk);
    #1;
    chk({tag, "_dw"},  32'(done[idx]), 32'(0));
  endtask

  logic [7:0] vals [8];

  initial begin
    int lat, nb, cnt;
    rst_n = 1'b0; start = '0; SUB = 1'b0; A = '0; B = '0;
    vals = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55, 8'hAA, 8'hFE};

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_busy", 32'(busy[i]), 0);
      chk("rst_done", 32'(done[i]), 0);
      chk("rst_S",    32'(s_o[i]),  0);
      chk("rst_CV",   32'({c_o[i], v_o[i]}), 0);
    end
    @(negedge clk) rst_n = 1'b1;

    // Hand-computed directed cases.
    run_op(0, 8'h7F, 8'h01, 1'b0, lat, nb);
    chk("add1_lat", 32'(lat), 9);
    chk("add1_bsy", 32'(nb), 8);
    chk("add1_S", 32'(s_o[0]), 32'h80);
    chk("add1_C", 32'(c_o[0]), 0);
    chk("add1_V", 32'(v_o[0]), 1);

    run_op(2, 8'hFF, 8'h01, 1'b0, lat, nb);
    chk("cy4_lat", 32'(lat), 3);
    chk("cy4_S", 32'(s_o[2]), 32'h00);
    chk("cy4_C", 32'(c_o[2]), 1);
    chk("cy4_V", 32'(v_o[2]), 0);

    run_op(1, 8'h03, 8'h05, 1'b1, lat, nb);
    chk("sub2_lat", 32'(lat), 5);
    chk("sub2_S", 32'(s_o[1]), 32'hFE);
    chk("sub2_C", 32'(c_o[1]), 0);
    chk("sub2_V", 32'(v_o[1]), 0);
    run_op(1, 8'h80, 8'h01, 1'b1, lat, nb);
    chk("sub2b_S", 32'(s_o[1]), 32'h7F);
    chk("sub2b_C", 32'(c_o[1]), 1);
    chk("sub2b_V", 32'(v_o[1]), 1);

    // Reset mid-RUN: outputs clear, op abandoned with no done pulse.
    @(negedge clk);
    A = 8'hFF; B = 8'h01; SUB = 1'b0; start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstrun_busy", 32'(busy[0]), 0);
    chk("rstrun_S", 32'(s_o[0]), 0);
    chk("rstrun_C", 32'(c_o[0]), 0);
    chk("rstrun_V", 32'(v_o[0]), 0);
    @(negedge clk) rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1 if (done[0]) cnt++;
    end
    chk("rstrun_nodone", 32'(cnt), 0);

    // Start during RUN is ignored and not queued.
    @(negedge clk);
    A = 8'h01; B = 8'h02; SUB = 1'b0; start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    A = 8'hFF; B = 8'hFF; start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 24 && cnt == 0; i++) begin
      @(posedge clk);
      #1 if (done[0]) cnt++;
    end
    chk("ign_done", 32'(cnt), 1);
    chk("ign_S", 32'(s_o[0]), 32'h03);
    chk("ign_CV", 32'({c_o[0], v_o[0]}), 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (done[0]) cnt++;
    end
    chk("ign_noqueue", 32'(cnt), 0);

    // Start held through DONE: second op follows with no IDLE gap.
    @(negedge clk);
    A = 8'h10; B = 8'h20; SUB = 1'b0; start[1] = 1'b1;
    @(posedge clk);
    #1;
    A = 8'h70; B = 8'h10;
    wait_done(1, lat, nb);
    chk("held1_lat", 32'(lat), 5);
    chk("held1_S", 32'(s_o[1]), 32'h30);
    chk("held1_CV", 32'({c_o[1], v_o[1]}), 0);
    @(posedge clk);
    #1;
    chk("held_dw", 32'(done[1]), 0);
    chk("held_nogap", 32'(busy[1]), 1);
    start[1] = 1'b0;
    wait_done(1, lat, nb);
    chk("held2_lat", 32'(lat), 5);
    chk("held2_S", 32'(s_o[1]), 32'h80);
    chk("held2_C", 32'(c_o[1]), 0);
    chk("held2_V", 32'(v_o[1]), 1);

    // Corner-value grid plus random pairs, every digit size, both modes.
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          for (int s = 0; s < 2; s++)
            op_check($sformatf("grid_d%0d_%h_%h_%0d", 1 << d, vals[i], vals[j], s),
                     d, vals[i], vals[j], 1'(s));
      for (int n = 0; n < 48; n++) begin
        logic [7:0] ra, rb;
        logic       rs;
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        rs = 1'($urandom_range(0, 1));
        op_check($sformatf("rnd_d%0d_%h_%h_%0d", 1 << d, ra, rb, rs), d, ra, rb, rs);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
